// File: rtl/uart_hex_display_loader_if.sv
// Bundles the UART RX byte stream and the loader's display-side outputs.
// master: the byte source and observer of the results.
// slave: the loader, which consumes bytes and drives the results.
interface uart_hex_display_loader_if #(
   parameter int DIGITS = 4
);
   localparam int CW = $clog2(DIGITS + 1);

   logic                  rx_dv;
   logic [7:0]            rx_byte;
   logic [4*DIGITS-1:0]   display_value;
   logic                  value_valid;
   logic                  error;
   logic [CW-1:0]         digit_count;

   modport master (
      output rx_dv,
      output rx_byte,
      input  display_value,
      input  value_valid,
      input  error,
      input  digit_count
   );

   modport slave (
      input  rx_dv,
      input  rx_byte,
      output display_value,
      output value_valid,
      output error,
      output digit_count
   );
endinterface

// File: rtl/uart_hex_display_loader.sv
// Parses ASCII hex text lines from a UART RX byte stream and commits the
// value to the 7-segment display on a CR/LF terminator. Bad characters,
// overlong lines and idle timeouts abandon the line without touching the
// displayed value.
module uart_hex_display_loader #(
   parameter int DIGITS         = 4,
   parameter int TIMEOUT_CYCLES = 100000000
) (
   input logic                    clock,
   input logic                    reset,
   uart_hex_display_loader_if.slave bus
);
   localparam int W  = 4 * DIGITS;
   localparam int CW = $clog2(DIGITS + 1);
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_COLLECT = 2'd1;
   localparam logic [1:0] ST_DISCARD = 2'd2;

   logic [1:0]    state_q,  state_d;
   logic [W-1:0]  shadow_q, shadow_d;
   logic [CW-1:0] count_q,  count_d;
   logic [TW-1:0] timer_q,  timer_d;
   logic [W-1:0]  value_q,  value_d;
   logic          valid_q,  valid_d;
   logic          error_q,  error_d;

   logic          is_hex;
   logic          is_term;
   logic          is_esc;
   logic [3:0]    nibble;

   // Classify the incoming byte and decode its hex nibble (either letter case).
   always_comb begin
      is_hex  = 1'b0;
      nibble  = 4'h0;
      is_term = (bus.rx_byte == 8'h0D) || (bus.rx_byte == 8'h0A);
      is_esc  = (bus.rx_byte == 8'h1B);
      if (bus.rx_byte >= 8'h30 && bus.rx_byte <= 8'h39) begin
         is_hex = 1'b1;
         nibble = bus.rx_byte[3:0];
      end else if ((bus.rx_byte >= 8'h41 && bus.rx_byte <= 8'h46) ||
                   (bus.rx_byte >= 8'h61 && bus.rx_byte <= 8'h66)) begin
         is_hex = 1'b1;
         nibble = bus.rx_byte[3:0] + 4'd9;
      end
   end

   // Line parser: a received byte always takes priority over the idle timeout.
   always_comb begin
      state_d  = state_q;
      shadow_d = shadow_q;
      count_d  = count_q;
      timer_d  = timer_q;
      value_d  = value_q;
      valid_d  = 1'b0;
      error_d  = error_q;

      if (bus.rx_dv) begin
         timer_d = '0;
         case (state_q)
            ST_IDLE: begin
               if (is_hex) begin
                  shadow_d = W'(nibble);
                  count_d  = CW'(1);
                  state_d  = ST_COLLECT;
               end else if (is_esc) begin
                  error_d = 1'b0;
               end else if (!is_term) begin
                  error_d = 1'b1;
                  state_d = ST_DISCARD;
               end
            end
            ST_COLLECT: begin
               if (is_hex) begin
                  if (count_q < CW'(DIGITS)) begin
                     shadow_d = (shadow_q << 4) | W'(nibble);
                     count_d  = count_q + CW'(1);
                  end else begin
                     error_d = 1'b1;
                     count_d = '0;
                     state_d = ST_DISCARD;
                  end
               end else if (is_term) begin
                  value_d = shadow_q;
                  valid_d = 1'b1;
                  error_d = 1'b0;
                  count_d = '0;
                  state_d = ST_IDLE;
               end else if (is_esc) begin
                  error_d = 1'b0;
                  count_d = '0;
                  state_d = ST_IDLE;
               end else begin
                  error_d = 1'b1;
                  count_d = '0;
                  state_d = ST_DISCARD;
               end
            end
            default: begin
               // Discarding: swallow everything until a terminator or escape.
               if (is_term) begin
                  state_d = ST_IDLE;
               end else if (is_esc) begin
                  error_d = 1'b0;
                  state_d = ST_IDLE;
               end
            end
         endcase
      end else if (state_q != ST_IDLE) begin
         if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_d = ST_IDLE;
            count_d = '0;
            timer_d = '0;
         end else begin
            timer_d = timer_q + TW'(1);
         end
      end else begin
         timer_d = '0;
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         shadow_q <= '0;
         count_q  <= '0;
         timer_q  <= '0;
         value_q  <= '0;
         valid_q  <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         shadow_q <= shadow_d;
         count_q  <= count_d;
         timer_q  <= timer_d;
         value_q  <= value_d;
         valid_q  <= valid_d;
         error_q  <= error_d;
      end
   end

   assign bus.display_value = value_q;
   assign bus.value_valid   = valid_q;
   assign bus.error         = error_q;
   assign bus.digit_count   = count_q;

endmodule

// File: tb/tb_uart_hex_display_loader.sv
// Randomised plus directed bench for uart_hex_display_loader, checked every
// cycle against a line-level behavioural model.
module tb_uart_hex_display_loader;
   localparam int DIGITS  = 4;
   localparam int TIMEOUT = 50;

   logic clock;
   logic reset;

   uart_hex_display_loader_if #(.DIGITS(DIGITS)) bus ();

   uart_hex_display_loader #(
      .DIGITS         (DIGITS),
      .TIMEOUT_CYCLES (TIMEOUT)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_checks = 0;
   int n_err    = 0;

   // Model state: the nibbles of the line being collected, plus flags.
   int          m_line[$];
   bit          m_coll  = 0;
   bit          m_disc  = 0;
   bit          m_err   = 0;
   bit          m_pulse = 0;
   logic [15:0] m_val   = 16'h0;
   int          m_idle  = 0;
   int          m_h;
   int          m_fold;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int hexval(input logic [7:0] b);
      int v;
      v = int'(b);
      if (v >= 48 && v <= 57)  return v - 48;
      if (v >= 65 && v <= 70)  return v - 55;
      if (v >= 97 && v <= 102) return v - 87;
      return -1;
   endfunction

   // Behavioural model: reacts to each sampled byte at the line level.
   initial begin
      forever begin
         @(posedge clock or negedge reset);
         if (!reset) begin
            m_line.delete();
            m_coll = 0; m_disc = 0; m_err = 0; m_pulse = 0;
            m_val = 16'h0; m_idle = 0;
         end else begin
            m_pulse = 0;
            if (bus.rx_dv) begin
               m_h = hexval(bus.rx_byte);
               m_idle = 0;
               if (m_disc) begin
                  if (bus.rx_byte == 8'h0D || bus.rx_byte == 8'h0A) m_disc = 0;
                  else if (bus.rx_byte == 8'h1B) begin m_disc = 0; m_err = 0; end
               end else if (m_coll) begin
                  if (m_h >= 0) begin
                     if (m_line.size() < DIGITS) m_line.push_back(m_h);
                     else begin m_err = 1; m_disc = 1; m_coll = 0; m_line.delete(); end
                  end else if (bus.rx_byte == 8'h0D || bus.rx_byte == 8'h0A) begin
                     m_fold = 0;
                     foreach (m_line[i]) m_fold = m_fold * 16 + m_line[i];
                     m_val = m_fold[15:0];
                     m_pulse = 1; m_err = 0; m_coll = 0; m_line.delete();
                  end else if (bus.rx_byte == 8'h1B) begin
                     m_err = 0; m_coll = 0; m_line.delete();
                  end else begin
                     m_err = 1; m_disc = 1; m_coll = 0; m_line.delete();
                  end
               end else begin
                  if (m_h >= 0) begin m_coll = 1; m_line.delete(); m_line.push_back(m_h); end
                  else if (bus.rx_byte == 8'h1B) m_err = 0;
                  else if (!(bus.rx_byte == 8'h0D || bus.rx_byte == 8'h0A)) begin
                     m_err = 1; m_disc = 1;
                  end
               end
            end else if (m_coll || m_disc) begin
               m_idle++;
               if (m_idle == TIMEOUT) begin
                  m_coll = 0; m_disc = 0; m_line.delete(); m_idle = 0;
               end
            end
         end
      end
   end

   // Compare DUT outputs against the model on every falling edge.
   always @(negedge clock) begin
      chk("display_value", 32'(bus.display_value), 32'(m_val));
      chk("value_valid",   32'(bus.value_valid),   32'(m_pulse));
      chk("error",         32'(bus.error),         32'(m_err));
      chk("digit_count",   32'(bus.digit_count),   m_coll ? m_line.size() : 0);
   end

   // Present one byte for exactly one cycle; called and returns on a falling edge.
   task automatic send_byte(input logic [7:0] b);
      bus.rx_dv   = 1'b1;
      bus.rx_byte = b;
      @(negedge clock);
      bus.rx_dv   = 1'b0;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i]);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clock);
   endtask

   logic [7:0] hex_chars [22];
   logic [7:0] bad_chars [6];

   initial begin
      string hs;
      hs = "0123456789ABCDEFabcdef";
      for (int i = 0; i < 22; i++) hex_chars[i] = hs[i];
      bad_chars[0] = 8'h47; bad_chars[1] = 8'h20; bad_chars[2] = 8'h67;
      bad_chars[3] = 8'h2F; bad_chars[4] = 8'h3A; bad_chars[5] = 8'h00;

      bus.rx_dv   = 1'b0;
      bus.rx_byte = 8'h00;
      reset = 1'b1;
      #2 reset = 1'b0;
      #30 reset = 1'b1;
      @(negedge clock);
      chk("reset_display", 32'(bus.display_value), 32'h0);
      chk("reset_error",   32'(bus.error), 32'h0);

      // Basic commit
      send_str("1A3F");
      chk("count_after_4", 32'(bus.digit_count), 32'd4);
      send_byte(8'h0D);
      chk("lit_1a3f", 32'(bus.display_value), 32'h1A3F);
      chk("lit_valid_pulse", 32'(bus.value_valid), 32'h1);
      idle(1);
      chk("lit_valid_drop", 32'(bus.value_valid), 32'h0);
      $display("txn \"1A3F\"CR -> display_value=%h", bus.display_value);

      // Lowercase, short line, LF terminator
      send_str("7f");
      send_byte(8'h0A);
      chk("lit_007f", 32'(bus.display_value), 32'h007F);
      $display("txn \"7f\"LF -> display_value=%h", bus.display_value);

      // Overflow
      send_str("12345");
      chk("overflow_error", 32'(bus.error), 32'h1);
      send_byte(8'h0D);
      chk("overflow_hold", 32'(bus.display_value), 32'h007F);
      chk("overflow_noval", 32'(bus.value_valid), 32'h0);
      $display("txn \"12345\"CR -> error=%0d display_value=%h", bus.error, bus.display_value);

      // Bad char, escape, recovery
      send_str("1G");
      chk("bad_error", 32'(bus.error), 32'h1);
      send_byte(8'h0D);
      send_byte(8'h1B);
      chk("esc_clear", 32'(bus.error), 32'h0);
      send_str("00FF");
      send_byte(8'h0D);
      chk("lit_00ff", 32'(bus.display_value), 32'h00FF);
      $display("txn \"1G\"CR ESC \"00FF\"CR -> display_value=%h", bus.display_value);

      // Timeout well past the limit
      send_str("AB");
      idle(60);
      send_str("C");
      send_byte(8'h0D);
      chk("lit_timeout_60", 32'(bus.display_value), 32'h000C);
      $display("txn \"AB\" idle60 \"C\"CR -> display_value=%h", bus.display_value);

      // Byte one cycle after the timeout fired
      send_str("AB");
      idle(TIMEOUT);
      send_str("C");
      chk("timeout_edge_after", 32'(bus.digit_count), 32'd1);
      send_byte(8'h0D);
      chk("lit_timeout_50", 32'(bus.display_value), 32'h000C);

      // Byte landing exactly on the timeout cycle is accepted
      send_str("AB");
      idle(TIMEOUT - 1);
      send_str("C");
      chk("timeout_edge_on", 32'(bus.digit_count), 32'd3);
      send_byte(8'h0D);
      chk("lit_timeout_49", 32'(bus.display_value), 32'h0ABC);
      $display("txn \"AB\" idle%0d \"C\"CR -> display_value=%h", TIMEOUT - 1, bus.display_value);

      // Asynchronous reset mid-line
      send_str("BEEF");
      #3 reset = 1'b0;
      #1 chk("async_reset_display", 32'(bus.display_value), 32'h0);
      chk("async_reset_count", 32'(bus.digit_count), 32'h0);
      #19 reset = 1'b1;
      @(negedge clock);
      send_byte(8'h0D);
      chk("post_reset_display", 32'(bus.display_value), 32'h0);
      chk("post_reset_noval", 32'(bus.value_valid), 32'h0);
      $display("txn \"BEEF\" reset CR -> display_value=%h", bus.display_value);

      // Randomised byte stream
      for (int n = 0; n < 600; n++) begin
         int r;
         logic [7:0] b;
         r = $urandom_range(0, 99);
         if (r < 62)      b = hex_chars[$urandom_range(0, 21)];
         else if (r < 78) b = ($urandom_range(0, 1) == 0) ? 8'h0D : 8'h0A;
         else if (r < 84) b = 8'h1B;
         else if (r < 92) b = bad_chars[$urandom_range(0, 5)];
         else             b = 8'($urandom_range(0, 255));
         send_byte(b);
         r = $urandom_range(0, 99);
         if (r < 3)       idle($urandom_range(TIMEOUT - 3, TIMEOUT + 3));
         else if (r < 30) idle($urandom_range(1, 3));
         if (bus.value_valid) $display("txn random commit -> display_value=%h", bus.display_value);
      end

      idle(2);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
